// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Summary  : One data-memory access per request over a req/ack bus, with
//            byte-lane steering, load extension and misalign/illegal fault.
//            Optional bus timeout fault enabled by defining LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_done;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    logic        w_illegal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_shift;
    logic [31:0] w_load_ext;
    logic        w_timeout;

    // Unsigned forms are load-only; halves and words must be naturally aligned.
    always_comb begin
        w_illegal = 1'b0;
        case (funct3)
            c_F3_B:  w_illegal = 1'b0;
            c_F3_BU: w_illegal = mem_write;
            c_F3_H:  w_illegal = addr[0];
            c_F3_HU: w_illegal = mem_write | addr[0];
            c_F3_W:  w_illegal = |addr[1:0];
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = wdata;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be        = 4'b0001 << addr[1:0];
                    w_wdata_rep = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_be        = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    w_be        = 4'b1111;
                    w_wdata_rep = wdata;
                end
            endcase
        end
    end

    assign w_shift = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_funct3)
            c_F3_B:  w_load_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            c_F3_BU: w_load_ext = {24'd0, w_shift[7:0]};
            c_F3_H:  w_load_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            c_F3_HU: w_load_ext = {16'd0, w_shift[15:0]};
            default: w_load_ext = w_shift;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;

    assign w_cnt_next = r_cnt + 1'b1;
    assign w_timeout  = (w_cnt_next == c_TIMEOUT);

    // REQ is only ever entered from IDLE, so clearing in IDLE clears on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) && !bus_ack) begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_rdata     <= 32'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_off    <= addr[1:0];
                        if (w_illegal) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state     <= S_REQ;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata_rep;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the same cycle as the timeout still completes normally.
                    if (bus_ack) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        if (!r_bus_we) begin
                            r_rdata <= w_load_ext;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_fault   <= 1'b1;
                        r_rdata   <= 32'd0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign fault     = r_fault;
    assign rdata     = r_rdata;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Summary  : Self-checking bench for load_store_unit against an arithmetic
//            reference model; adds timeout scenarios when LSU_TIMEOUT_EN is set.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif
    localparam int BUSY_ACK = (TO >= 5) ? 5 : TO;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        busy, done, fault, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_rdata = 32'd0;

    typedef struct {
        int          done_cyc;
        logic        fault;
        logic [31:0] rdata;
        logic        req_seen;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic        busy1;
    } res_t;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    // ---------------- reference model ----------------
    function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (we && f3 >= 3'd4) return 1'b0;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (!we) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        if (f3 == 3'd1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'd0: return ((v & 32'hFF) >= 32'd128) ? (v & 32'hFF) - 32'd256 : (v & 32'hFF);
            3'd4: return v & 32'hFF;
            3'd1: return ((v & 32'hFFFF) >= 32'd32768) ? (v & 32'hFFFF) - 32'd65536 : (v & 32'hFFFF);
            3'd5: return v & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    // ---------------- driver: one access, returns what the bus and core saw ----------------
    // ack_cyc = REQ cycle (1-based) in which bus_ack is high; 0 = never.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_cyc, input int restart_cyc, output res_t r);
        int reqn;
        r.done_cyc = -1; r.fault = 1'b0; r.rdata = 32'd0; r.req_seen = 1'b0; r.we = 1'b0;
        r.baddr = 32'd0; r.be = 4'd0; r.bwdata = 32'd0; r.busy1 = 1'b0;
        reqn = 0;
        @(negedge clk);
        start = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0; mem_write = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) r.busy1 = busy;
            if (bus_req && !r.req_seen) begin
                r.req_seen = 1'b1; r.we = bus_we; r.baddr = bus_addr; r.be = bus_be; r.bwdata = bus_wdata;
            end
            if (done) begin
                r.done_cyc = c; r.fault = fault; r.rdata = rdata;
                break;
            end
            if (bus_req) begin
                reqn++;
                bus_ack = (reqn == ack_cyc);
                bus_rdata = (reqn == ack_cyc) ? rd : $urandom;
            end else begin
                bus_ack = 1'($urandom);
                bus_rdata = $urandom;
            end
            if (c == restart_cyc) begin
                start = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (r.done_cyc < 0) begin
            @(negedge clk); rst = 1'b0; #2; rst = 1'b1;
            m_rdata = 32'd0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, fault, bus_req, bus_we} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, fault, bus_req, bus_we});
        end
        checks++;
        if ({bus_addr, bus_be, bus_wdata, rdata} !== 100'd0) begin
            errors++; $display("FAIL reset_data: got addr=%h be=%h wd=%h rd=%h expected all 0", bus_addr, bus_be, bus_wdata, rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed();
        res_t r;
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, r);
        checks++; if (r.baddr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h expected 00000100", r.baddr); end
        checks++; if (r.be !== 4'hF) begin errors++; $display("FAIL lw_be: got %h expected f", r.be); end
        checks++; if (r.done_cyc !== 2) begin errors++; $display("FAIL lw_done_cycle: got %0d expected 2", r.done_cyc); end
        checks++; if (r.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", r.rdata); end
        checks++; if (r.fault !== 1'b0) begin errors++; $display("FAIL lw_fault: got %b expected 0", r.fault); end
        run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 0, r);
        checks++; if (r.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", r.rdata); end
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 0, r);
        checks++; if (r.rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h expected 00000080", r.rdata); end
        run_access(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 1, 0, r);
        checks++; if (r.we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b expected 1", r.we); end
        checks++; if (r.baddr !== 32'h20) begin errors++; $display("FAIL sh_addr: got %h expected 00000020", r.baddr); end
        checks++; if (r.be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", r.be); end
        checks++; if (r.bwdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", r.bwdata); end
        checks++; if (r.rdata !== 32'h00000080) begin errors++; $display("FAIL sh_rdata_held: got %h expected 00000080", r.rdata); end
        m_rdata = 32'h00000080;
    endtask

    task automatic test_fault();
        res_t r;
        run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 1, 0, r);
        checks++; if (r.done_cyc !== 1) begin errors++; $display("FAIL lw_mis_done_cycle: got %0d expected 1", r.done_cyc); end
        checks++; if (r.fault !== 1'b1) begin errors++; $display("FAIL lw_mis_fault: got %b expected 1", r.fault); end
        checks++; if (r.rdata !== 32'd0) begin errors++; $display("FAIL lw_mis_rdata: got %h expected 0", r.rdata); end
        checks++; if (r.req_seen !== 1'b0) begin errors++; $display("FAIL lw_mis_bus_req: got %b expected 0", r.req_seen); end
        run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 2, 0, r);
        run_access(1'b1, 3'b001, 32'h101, 32'h1234, 32'h0, 1, 0, r);
        checks++; if (r.done_cyc !== 1) begin errors++; $display("FAIL sh_mis_done_cycle: got %0d expected 1", r.done_cyc); end
        checks++; if (r.fault !== 1'b1) begin errors++; $display("FAIL sh_mis_fault: got %b expected 1", r.fault); end
        checks++; if (r.rdata !== 32'd0) begin errors++; $display("FAIL sh_mis_rdata: got %h expected 0", r.rdata); end
        checks++; if (r.req_seen !== 1'b0) begin errors++; $display("FAIL sh_mis_bus_req: got %b expected 0", r.req_seen); end
        m_rdata = 32'd0;
    endtask

    task automatic test_busy_restart_reset();
        res_t r;
        run_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h13572468, BUSY_ACK, 3, r);
        checks++; if (r.done_cyc !== BUSY_ACK + 1) begin errors++; $display("FAIL slow_done_cycle: got %0d expected %0d", r.done_cyc, BUSY_ACK + 1); end
        checks++; if (r.rdata !== 32'h13572468) begin errors++; $display("FAIL slow_rdata: got %h expected 13572468", r.rdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, bus_req, done} !== 3'b000) begin
                errors++; $display("FAIL restart_ignored_%0d: got busy/req/done=%b expected 000", i, {busy, bus_req, done});
            end
        end
        @(negedge clk);
        start = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h200; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        start = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b expected 1", bus_req); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, fault, bus_req, bus_we} !== 5'b0) begin
            errors++; $display("FAIL rst_async_ctrl: got %b expected 00000", {busy, done, fault, bus_req, bus_we});
        end
        checks++;
        if ({bus_addr, bus_be, bus_wdata, rdata} !== 100'd0) begin
            errors++; $display("FAIL rst_async_data: got addr=%h be=%h wd=%h rd=%h expected all 0", bus_addr, bus_be, bus_wdata, rdata);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rst_no_done: got done/busy=%b expected 00", {done, busy}); end
        m_rdata = 32'd0;
    endtask

    task automatic test_random();
        res_t r;
        logic we, lg;
        logic [2:0] f3;
        logic [31:0] a, wd, rd;
        int ack;
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom); f3 = 3'($urandom); a = $urandom; wd = $urandom; rd = $urandom;
            ack = $urandom_range(1, (TO < 4) ? TO : 4);
            lg = m_legal(we, f3, a);
            run_access(we, f3, a, wd, rd, ack, 0, r);
            if (!lg) m_rdata = 32'd0;
            else if (!we) m_rdata = m_load(f3, a, rd);
            checks++; if (r.done_cyc !== (lg ? ack + 1 : 1)) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d expected %0d", n, r.done_cyc, lg ? ack + 1 : 1); end
            checks++; if (r.fault !== !lg) begin errors++; $display("FAIL rnd%0d_fault: got %b expected %b", n, r.fault, !lg); end
            checks++; if (r.rdata !== m_rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, r.rdata, m_rdata); end
            checks++; if (r.req_seen !== lg) begin errors++; $display("FAIL rnd%0d_bus_req: got %b expected %b", n, r.req_seen, lg); end
            checks++; if (r.busy1 !== 1'b1) begin errors++; $display("FAIL rnd%0d_busy: got %b expected 1", n, r.busy1); end
            if (lg) begin
                checks++; if (r.we !== we) begin errors++; $display("FAIL rnd%0d_we: got %b expected %b", n, r.we, we); end
                checks++; if (r.baddr !== (a & ~32'd3)) begin errors++; $display("FAIL rnd%0d_addr: got %h expected %h", n, r.baddr, a & ~32'd3); end
                checks++; if (r.be !== m_be(we, f3, a)) begin errors++; $display("FAIL rnd%0d_be: got %h expected %h", n, r.be, m_be(we, f3, a)); end
                if (we) begin
                    checks++; if (r.bwdata !== m_wdata(f3, wd)) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, r.bwdata, m_wdata(f3, wd)); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        logic [31:0] rd;
        for (int n = 0; n < 6; n++) begin
            rd = $urandom;
            run_access(1'(n % 2), 3'b010, 32'h300 + 32'(4 * n), 32'h0, rd, 1, 0, r);
            if (n % 2 == 0) m_rdata = rd;
            checks++; if (r.done_cyc !== 2) begin errors++; $display("FAIL b2b%0d_done_cycle: got %0d expected 2", n, r.done_cyc); end
            checks++; if (r.rdata !== m_rdata) begin errors++; $display("FAIL b2b%0d_rdata: got %h expected %h", n, r.rdata, m_rdata); end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        res_t r;
        run_access(1'b0, 3'b010, 32'h0, 32'h0, 32'h55AA55AA, 0, 0, r);
        checks++; if (r.done_cyc !== TO + 1) begin errors++; $display("FAIL to_done_cycle: got %0d expected %0d", r.done_cyc, TO + 1); end
        checks++; if (r.fault !== 1'b1) begin errors++; $display("FAIL to_fault: got %b expected 1", r.fault); end
        checks++; if (r.rdata !== 32'd0) begin errors++; $display("FAIL to_rdata: got %h expected 0", r.rdata); end
        run_access(1'b0, 3'b010, 32'h0, 32'h0, 32'h55AA55AA, TO, 0, r);
        checks++; if (r.done_cyc !== TO + 1) begin errors++; $display("FAIL to_ack_done_cycle: got %0d expected %0d", r.done_cyc, TO + 1); end
        checks++; if (r.fault !== 1'b0) begin errors++; $display("FAIL to_ack_fault: got %b expected 0", r.fault); end
        checks++; if (r.rdata !== 32'h55AA55AA) begin errors++; $display("FAIL to_ack_rdata: got %h expected 55aa55aa", r.rdata); end
        m_rdata = 32'h55AA55AA;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_fault();
        test_busy_restart_reset();
        test_random();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
